// File: rtl/pdc_pkg.sv
// Shared types and constants for the path-delay measurement controller.
package pdc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESET,
        LAUNCH,
        REPORT,
        DONE
    } state_t;

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

    // The first edge measured on a path; only a pure-fall sweep starts falling.
    // The launch initial level equals the edge bit (rise starts low, fall starts high).
    function automatic logic firstEdge(input logic [1:0] m);
        return (m == MODE_FALL) ? EDGE_FALL : EDGE_RISE;
    endfunction

endpackage

// File: rtl/pdc_sync2.sv
// Two-flop synchroniser bringing the asynchronous path outputs into the clk domain.
module pdc_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Both stages clear on reset so detection starts from a known low level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/path_delay_ctrl.sv
// Path-delay measurement controller: sweeps each path, launches a transition,
// counts cycles until the synchronised output follows and reports one word per edge.
module path_delay_ctrl #(
    parameter int NUM_PATHS = 4,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 1000,
    localparam int IDX_W    = (NUM_PATHS > 1) ? $clog2(NUM_PATHS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [NUM_PATHS-1:0] path_result,
    output logic [NUM_PATHS-1:0] path_input,
    output logic                 busy,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [IDX_W-1:0]     res_path,
    output logic                 res_edge,
    output logic [CNT_W-1:0]     res_count,
    output logic                 res_timeout,
    output logic                 done
);

    import pdc_pkg::*;

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    state_t               r_state;
    logic [1:0]           r_mode;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_edge;
    logic [CNT_W-1:0]     r_cnt;
    logic [NUM_PATHS-1:0] r_pathIn;
    logic                 r_busy;
    logic                 r_valid;
    logic [IDX_W-1:0]     r_resPath;
    logic                 r_resEdge;
    logic [CNT_W-1:0]     r_resCount;
    logic                 r_resTimeout;
    logic                 r_done;

    logic [NUM_PATHS-1:0] w_sync;
    logic                 w_sel;
    logic                 w_last;
    logic [NUM_PATHS-1:0] w_launchVec;

    pdc_sync2 #(
        .WIDTH(NUM_PATHS)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (path_result),
        .o_q   (w_sync)
    );

    assign w_sel       = w_sync[r_idx];
    assign w_last      = (r_idx == IDX_W'(NUM_PATHS - 1));
    assign w_launchVec = {NUM_PATHS{r_edge}} ^ (NUM_PATHS'(1) << r_idx);

    // Sweep FSM with counter, path index and registered result/launch outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_mode       <= MODE_RISE;
            r_idx        <= '0;
            r_edge       <= EDGE_RISE;
            r_cnt        <= '0;
            r_pathIn     <= '0;
            r_busy       <= 1'b0;
            r_valid      <= 1'b0;
            r_resPath    <= '0;
            r_resEdge    <= 1'b0;
            r_resCount   <= '0;
            r_resTimeout <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mode   <= (mode == MODE_FALL || mode == MODE_BOTH) ? mode : MODE_RISE;
                        r_idx    <= '0;
                        r_edge   <= firstEdge(mode);
                        r_cnt    <= '0;
                        r_pathIn <= {NUM_PATHS{firstEdge(mode)}};
                        r_busy   <= 1'b1;
                        r_state  <= PRESET;
                    end
                end
                PRESET: begin
                    if (w_sel == r_edge) begin
                        r_cnt    <= '0;
                        r_pathIn <= w_launchVec;
                        r_state  <= LAUNCH;
                    end else if (r_cnt == CNT_LIMIT) begin
                        r_resPath    <= r_idx;
                        r_resEdge    <= r_edge;
                        r_resCount   <= '0;
                        r_resTimeout <= 1'b1;
                        r_valid      <= 1'b1;
                        r_state      <= REPORT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                LAUNCH: begin
                    if (w_sel != r_edge) begin
                        r_resPath    <= r_idx;
                        r_resEdge    <= r_edge;
                        r_resCount   <= r_cnt;
                        r_resTimeout <= 1'b0;
                        r_valid      <= 1'b1;
                        r_state      <= REPORT;
                    end else if (r_cnt == CNT_LIMIT) begin
                        r_resPath    <= r_idx;
                        r_resEdge    <= r_edge;
                        r_resCount   <= CNT_LIMIT;
                        r_resTimeout <= 1'b1;
                        r_valid      <= 1'b1;
                        r_state      <= REPORT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        r_valid <= 1'b0;
                        r_cnt   <= '0;
                        if (r_mode == MODE_BOTH && r_edge == EDGE_RISE) begin
                            r_edge   <= EDGE_FALL;
                            r_pathIn <= {NUM_PATHS{EDGE_FALL}};
                            r_state  <= PRESET;
                        end else if (w_last) begin
                            r_pathIn <= '0;
                            r_done   <= 1'b1;
                            r_state  <= DONE;
                        end else begin
                            r_idx    <= r_idx + IDX_W'(1);
                            r_edge   <= firstEdge(r_mode);
                            r_pathIn <= {NUM_PATHS{firstEdge(r_mode)}};
                            r_state  <= PRESET;
                        end
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign path_input  = r_pathIn;
    assign busy        = r_busy;
    assign res_valid   = r_valid;
    assign res_path    = r_resPath;
    assign res_edge    = r_resEdge;
    assign res_count   = r_resCount;
    assign res_timeout = r_resTimeout;
    assign done        = r_done;

endmodule
